// File: rtl/if_stage.sv
// Instruction fetch stage: one outstanding imem request, one-word skid buffer, redirect/kill handling.
// Latency: with an ack in the cycle the address is presented, one instruction reaches ID per cycle.
// Backpressure: if_en=0 parks an acked word in the skid buffer and drops imem_req until ID takes it.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_rst,
  input  logic        if_en,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  output logic        if_valid
);

  typedef enum logic [1:0] {FETCH, HOLD, KILL} state_t;

  localparam logic [31:0] RESET_PC_AL = RESET_PC & ~32'h3;

  state_t      state, state_nx;
  logic [31:0] pc, pc_nx;
  logic [31:0] kill_addr, kill_addr_nx;   // address of the request being discarded
  logic [31:0] buf_data, buf_data_nx;
  logic [31:0] buf_pc, buf_pc_nx;
  logic [31:0] data_nx, ipc_nx;
  logic        valid_nx;
  logic        ack, pending, deliver;

  // In KILL the memory still sees the abandoned address; pc already holds the new target.
  assign imem_req  = (state != HOLD);
  assign imem_addr = (state == KILL) ? kill_addr : pc;
  assign ack       = imem_req & imem_ack;
  assign pending   = imem_req & ~imem_ack;

  // Next-state and output-register logic, priority if_rst > redirect > normal flow.
  always_comb begin
    state_nx     = state;
    pc_nx        = pc;
    kill_addr_nx = kill_addr;
    buf_data_nx  = buf_data;
    buf_pc_nx    = buf_pc;
    data_nx      = inst_data;
    ipc_nx       = inst_pc;
    valid_nx     = if_valid;
    deliver      = 1'b0;

    if (if_rst || redirect_valid) begin
      pc_nx = if_rst ? RESET_PC_AL : (redirect_pc & ~32'h3);
      // An unacked request must still be drained; remember its address.
      if (pending) begin
        state_nx     = KILL;
        kill_addr_nx = imem_addr;
      end else begin
        state_nx = FETCH;
      end
      if (if_rst) begin
        data_nx  = 32'h0;
        ipc_nx   = 32'h0;
        valid_nx = 1'b0;
      end else if (if_en) begin
        data_nx  = 32'h0;
        valid_nx = 1'b0;
      end
    end else begin
      case (state)
        FETCH: begin
          if (ack) begin
            pc_nx = pc + 32'd4;
            if (if_en) begin
              data_nx  = imem_rdata;
              ipc_nx   = pc;
              valid_nx = 1'b1;
              deliver  = 1'b1;
            end else begin
              buf_data_nx = imem_rdata;
              buf_pc_nx   = pc;
              state_nx    = HOLD;
            end
          end
        end
        HOLD: begin
          if (if_en) begin
            data_nx  = buf_data;
            ipc_nx   = buf_pc;
            valid_nx = 1'b1;
            deliver  = 1'b1;
            state_nx = FETCH;
          end
        end
        KILL: begin
          if (ack) state_nx = FETCH;
        end
        default: state_nx = FETCH;
      endcase
      // ID advanced but nothing new arrived: hand it a NOP bubble.
      if (if_en && !deliver) begin
        data_nx  = 32'h0;
        valid_nx = 1'b0;
      end
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= FETCH;
      pc        <= RESET_PC_AL;
      kill_addr <= RESET_PC_AL;
      buf_data  <= 32'h0;
      buf_pc    <= 32'h0;
      inst_data <= 32'h0;
      inst_pc   <= 32'h0;
      if_valid  <= 1'b0;
    end else begin
      state     <= state_nx;
      pc        <= pc_nx;
      kill_addr <= kill_addr_nx;
      buf_data  <= buf_data_nx;
      buf_pc    <= buf_pc_nx;
      inst_data <= data_nx;
      inst_pc   <= ipc_nx;
      if_valid  <= valid_nx;
    end
  end

endmodule
